ddr_axi_bist_engine: RTL
========================

// Module: ddr_axi_bist_engine
// PURPOSE
//  Parametrised AXI4 self-test engine for the DDR3 core's AXI port 0. Replaces the separate main/wr/rd test
//  controllers with one FSM. Each pass writes a pattern over the test space, then reads it back and checks it.
//  Supports configurable width, burst length, address mode, looping, error counting and a heartbeat LED.
// PARAMETERS
//  DATA_W        128        AXI data width in bits; must be a power of two and at least 32.
//  ADDR_W        32         AXI address width.
//  MEM_SPACE_AW  27         Byte-address bits covered by the test; 10 is used in simulation.
//  BURST_LEN     16         Beats per burst, 1..256; awlen = arlen = BURST_LEN-1.
//  ID_W          8          AXI ID width; the engine always drives ID 0.
//  HB_TH         33000000   Heartbeat half-period in axi_clk cycles.
// PORTS
//  axi_clk        in   1        Clock.
//  top_rst_n      in   1        Reset: asynchronous, active-low.
//  ddrc_init_done in   1        DDR controller initialisation done.
//  start          in   1        One-cycle pulse that begins a run. Ignored while busy.
//  addr_mode      in   1        0 = incrementing addresses; 1 = reversed (descending) addresses.
//  loop_en        in   1        1 = repeat passes until this input is cleared.
//  aw*/w*/b*      AXI4 write channels: awid, awaddr, awlen, awsize, awburst, awvalid, awready;
//                 wdata, wstrb, wlast, wvalid, wready; bid, bresp, bvalid, bready.
//  ar*/r*         AXI4 read channels: arid, araddr, arlen, arsize, arburst, arvalid, arready;
//                 rid, rdata, rresp, rlast, rvalid, rready.
//  busy           out  1        High from the accepted start until DONE.
//  pass_done      out  1        One-cycle pulse at the end of each pass.
//  pass_cnt       out  16       Completed passes; wraps from 0xFFFF to 0.
//  err_cnt        out  16       Error count; saturates at 0xFFFF.
//  err_flag       out  1        Sticky; set on the first error and cleared by an accepted start.
//  clk_led        out  1        Heartbeat LED.
// BEHAVIOUR
//  Reset values: all valid and ready outputs 0; busy=0; pass_done=0; counters=0; err_flag=0; clk_led=1.
//   An asserted reset in mid-burst aborts immediately to IDLE; no AXI transfer is completed afterwards.
//  FSM states and transitions:
//   IDLE     -> WAIT_INIT on start. WAIT_INIT -> WR_ADDR once ddrc_init_done=1.
//   WR_ADDR  -> WR_DATA on the AW handshake. WR_DATA -> WR_RESP on the handshake of the last beat.
//   WR_RESP  -> WR_ADDR (next burst) or RD_ADDR (after the final burst, address counter reloaded).
//   RD_ADDR  -> RD_DATA on the AR handshake. RD_DATA -> RD_ADDR (next burst), or NEXT on the last rlast.
//   NEXT     -> WR_ADDR if loop_en=1, otherwise DONE. DONE -> IDLE after one cycle.
//  Handshake and transaction rules:
//   Each valid is held, with a stable payload, until its ready is seen. One burst is outstanding at a time.
//   bready=1 only in WR_RESP; rready=1 only in RD_DATA.
//   awsize = arsize = log2(DATA_W/8); burst type is INCR; wstrb is all ones.
//  Addressing:
//   Burst stride S = BURST_LEN*DATA_W/8 bytes; bursts per phase N = 2^MEM_SPACE_AW / S.
//   Burst k has address k*S in mode 0 and (N-1-k)*S in mode 1.
//  Data pattern:
//   Each beat carries DATA_W/32 copies of (beat_byte_addr[31:0] ^ {16'hA5A5, pass_cnt}).
//   beat_byte_addr = burst base + beat*DATA_W/8.
//  Checking (err_cnt +1 per event):
//   any rdata beat that differs from the expected pattern;
//   rresp != 0 or bresp != 0;
//   rlast missing on beat BURST_LEN-1, or rlast asserted early.
//   Error events and counter updates take effect in the cycle after the beat or response handshake.
//  Pass and run end:
//   pass_cnt increments and pass_done pulses on entry to NEXT.
//   Clearing loop_en mid-pass lets the current pass complete.
//  Heartbeat: a cycle counter clears at HB_TH and toggles clk_led; it runs independently of the FSM.
// CONFIGURATION
//  DDR_BIST_ERR_CAPTURE_EN
//   Defined: adds outputs first_err_addr[ADDR_W-1:0], first_err_exp[31:0] and first_err_act[31:0].
//   These are latched on the first data-mismatch error after start and held until the next accepted start.
//   They are reset to 0.
//   Undefined: these ports and registers do not exist; all other behaviour is identical.
// TESTING
//  Setup: MEM_SPACE_AW=10, DATA_W=128, BURST_LEN=16, which gives S=256 and N=4. Use an ideal AXI memory model.
//  1. start, addr_mode=0, loop_en=0 -> 4 AW bursts at 0x000, 0x100, 0x200, 0x300, then 4 AR bursts in the
//     same order; pass_done pulses once; pass_cnt=1; err_cnt=0; busy falls.
//  2. addr_mode=1 -> AW and AR addresses 0x300, 0x200, 0x100, 0x000; err_cnt=0.
//  3. Model flips bit 5 of one read beat at 0x110 -> err_cnt=1 and err_flag=1.
//     With DDR_BIST_ERR_CAPTURE_EN: first_err_addr=0x110.
//  4. Random awready/wready/arready/rvalid stalls of 0-7 cycles -> all AXI valid-hold rules respected;
//     err_cnt=0.
//  5. loop_en=1 for 3 passes, then cleared -> pass_cnt=3 or 4; a pattern seed that changes per pass is checked.
//  6. Reset asserted mid-WR_DATA -> next cycle all valids are 0 and the FSM is in IDLE.
//     A subsequent start holds in WAIT_INIT while ddrc_init_done=0.

Source files
------------

// File: rtl/ddr_axi_bist_engine_if.sv
// AXI4 bundle between the DDR BIST engine (master) and the DDR core's AXI port 0 (slave).
// Handshake: a transfer happens on a rising edge where valid and ready are both 1; valid and its payload are held until then.
interface ddr_axi_bist_engine_if #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 32,
  parameter int ID_W   = 8
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bid, bresp, bvalid, output bready,
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready
  );

  modport slave (
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bid, bresp, bvalid, input bready,
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready
  );
endinterface

// File: rtl/ddr_axi_bist_engine.sv
// Write-then-read-back AXI4 self-test engine for DDR port 0, one burst outstanding at a time.
// Optional first-error capture ports are enabled by defining DDR_BIST_ERR_CAPTURE_EN.
module ddr_axi_bist_engine #(
  parameter int DATA_W       = 128,
  parameter int ADDR_W       = 32,
  parameter int MEM_SPACE_AW = 27,
  parameter int BURST_LEN    = 16,
  parameter int ID_W         = 8,
  parameter int HB_TH        = 33000000
) (
  input  logic        axi_clk,
  input  logic        top_rst_n,
  input  logic        ddrc_init_done_i,
  input  logic        start_i,
  input  logic        addr_mode_i,
  input  logic        loop_en_i,
  ddr_axi_bist_engine_if.master axi,
  output logic        busy_o,
  output logic        pass_done_o,
  output logic [15:0] pass_cnt_o,
  output logic [15:0] err_cnt_o,
  output logic        err_flag_o,
  output logic        clk_led_o,
  output logic [3:0]  state_o
`ifdef DDR_BIST_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr_o,
  output logic [31:0]       first_err_exp_o,
  output logic [31:0]       first_err_act_o
`endif
);
  localparam int BYTES  = DATA_W / 8;
  localparam int STRIDE = BURST_LEN * BYTES;
  localparam int NBURST = (1 << MEM_SPACE_AW) / STRIDE;
  localparam int BW     = (NBURST > 1) ? $clog2(NBURST) : 1;
  localparam int LANES  = DATA_W / 32;

  typedef enum logic [3:0] {
    IDLE, WAIT_INIT, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, NEXT, DONE
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [7:0]      beat_q, beat_d;
  logic            mode_q, mode_d;
  logic [15:0]     pass_cnt_q, pass_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic            err_flag_q, err_flag_d;
  logic [31:0]     hb_cnt_q;
  logic            clk_led_q;

  logic aw_fire, w_fire, b_fire, ar_fire, r_fire, start_ok;
  logic last_burst, last_beat;
  logic [BW-1:0]     burst_idx;
  logic [ADDR_W-1:0] burst_base, beat_addr;
  logic [31:0]       pat;
  logic [DATA_W-1:0] exp_data;
  logic data_err, last_err, resp_err;
  logic [1:0]  err_inc;
  logic [16:0] err_sum;
  logic        unused_ids;

  assign aw_fire  = axi.awvalid & axi.awready;
  assign w_fire   = axi.wvalid & axi.wready;
  assign b_fire   = axi.bvalid & axi.bready;
  assign ar_fire  = axi.arvalid & axi.arready;
  assign r_fire   = axi.rvalid & axi.rready;
  assign start_ok = (state_q == IDLE) & start_i;

  assign last_burst = (burst_q == BW'(NBURST - 1));
  assign last_beat  = (beat_q == 8'(BURST_LEN - 1));
  // Descending mode walks the same burst slots from the top of the test space down.
  assign burst_idx  = mode_q ? (BW'(NBURST - 1) - burst_q) : burst_q;
  assign burst_base = ADDR_W'(burst_idx) * ADDR_W'(STRIDE);
  assign beat_addr  = burst_base + ADDR_W'(beat_q) * ADDR_W'(BYTES);
  assign pat        = 32'(beat_addr) ^ {16'hA5A5, pass_cnt_q};
  assign exp_data   = {LANES{pat}};

  assign data_err = r_fire & (axi.rdata != exp_data);
  assign last_err = r_fire & (axi.rlast != last_beat);
  assign resp_err = (r_fire & (axi.rresp != 2'b00)) | (b_fire & (axi.bresp != 2'b00));
  assign err_inc  = {1'b0, data_err} + {1'b0, last_err} + {1'b0, resp_err};
  assign err_sum  = {1'b0, err_cnt_q} + 17'(err_inc);
  assign unused_ids = ^{axi.bid, axi.rid};

  always_ff @(posedge axi_clk or negedge top_rst_n) begin
    if (!top_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start_i) state_d = WAIT_INIT;
      WAIT_INIT: if (ddrc_init_done_i) state_d = WR_ADDR;
      WR_ADDR:   if (aw_fire) state_d = WR_DATA;
      WR_DATA:   if (w_fire && last_beat) state_d = WR_RESP;
      WR_RESP:   if (b_fire) state_d = last_burst ? RD_ADDR : WR_ADDR;
      RD_ADDR:   if (ar_fire) state_d = RD_DATA;
      RD_DATA:   if (r_fire && last_beat) state_d = last_burst ? NEXT : RD_ADDR;
      NEXT:      state_d = loop_en_i ? WR_ADDR : DONE;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    axi.awvalid = (state_q == WR_ADDR);
    axi.wvalid  = (state_q == WR_DATA);
    axi.bready  = (state_q == WR_RESP);
    axi.arvalid = (state_q == RD_ADDR);
    axi.rready  = (state_q == RD_DATA);
    busy_o      = (state_q != IDLE);
    pass_done_o = (state_q == NEXT);
  end

  assign axi.awid    = '0;
  assign axi.awaddr  = burst_base;
  assign axi.awlen   = 8'(BURST_LEN - 1);
  assign axi.awsize  = 3'($clog2(BYTES));
  assign axi.awburst = 2'b01;
  assign axi.wdata   = exp_data;
  assign axi.wstrb   = '1;
  assign axi.wlast   = last_beat;
  assign axi.arid    = '0;
  assign axi.araddr  = burst_base;
  assign axi.arlen   = 8'(BURST_LEN - 1);
  assign axi.arsize  = 3'($clog2(BYTES));
  assign axi.arburst = 2'b01;

  always_comb begin
    burst_d    = burst_q;
    beat_d     = beat_q;
    mode_d     = mode_q;
    pass_cnt_d = pass_cnt_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    if (start_ok) begin
      mode_d     = addr_mode_i;
      err_flag_d = 1'b0;
      burst_d    = '0;
      beat_d     = '0;
    end
    if (w_fire || r_fire) beat_d = last_beat ? 8'd0 : beat_q + 8'd1;
    // The burst counter wraps after the final write burst so the read phase restarts at burst 0.
    if (b_fire || (r_fire && last_beat)) burst_d = last_burst ? '0 : burst_q + BW'(1);
    if (state_q == RD_DATA && state_d == NEXT) pass_cnt_d = pass_cnt_q + 16'd1;
    if (err_inc != 2'd0) err_flag_d = 1'b1;
  end

  always_ff @(posedge axi_clk or negedge top_rst_n) begin
    if (!top_rst_n) begin
      burst_q    <= '0;
      beat_q     <= '0;
      mode_q     <= 1'b0;
      pass_cnt_q <= '0;
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      burst_q    <= burst_d;
      beat_q     <= beat_d;
      mode_q     <= mode_d;
      pass_cnt_q <= pass_cnt_d;
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  always_ff @(posedge axi_clk or negedge top_rst_n) begin
    if (!top_rst_n) begin
      hb_cnt_q  <= '0;
      clk_led_q <= 1'b1;
    end else if (hb_cnt_q == 32'(HB_TH - 1)) begin
      hb_cnt_q  <= '0;
      clk_led_q <= ~clk_led_q;
    end else begin
      hb_cnt_q  <= hb_cnt_q + 32'd1;
    end
  end

  assign pass_cnt_o = pass_cnt_q;
  assign err_cnt_o  = err_cnt_q;
  assign err_flag_o = err_flag_q;
  assign clk_led_o  = clk_led_q;
  assign state_o    = state_q;

`ifdef DDR_BIST_ERR_CAPTURE_EN
  logic              cap_q;
  logic [ADDR_W-1:0] cap_addr_q;
  logic [31:0]       cap_exp_q, cap_act_q, act_word;

  // Report the lowest 32-bit lane that disagrees with the pattern.
  always_comb begin
    act_word = axi.rdata[31:0];
    for (int i = LANES - 1; i >= 0; i--)
      if (axi.rdata[i*32 +: 32] != pat) act_word = axi.rdata[i*32 +: 32];
  end

  always_ff @(posedge axi_clk or negedge top_rst_n) begin
    if (!top_rst_n) begin
      cap_q      <= 1'b0;
      cap_addr_q <= '0;
      cap_exp_q  <= '0;
      cap_act_q  <= '0;
    end else if (start_ok) begin
      cap_q      <= 1'b0;
      cap_addr_q <= '0;
      cap_exp_q  <= '0;
      cap_act_q  <= '0;
    end else if (data_err && !cap_q) begin
      cap_q      <= 1'b1;
      cap_addr_q <= beat_addr;
      cap_exp_q  <= pat;
      cap_act_q  <= act_word;
    end
  end

  assign first_err_addr_o = cap_addr_q;
  assign first_err_exp_o  = cap_exp_q;
  assign first_err_act_o  = cap_act_q;
`else
  // Without capture, only the error counter and sticky flag record failures.
`endif
endmodule
